// File: rtl/mux_pipeline_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_pipeline_pkg : stage count and per-stage entry bookkeeping for mux_pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
package mux_pipeline_pkg;

  function automatic int calc_stages(input int sel_bits, input int stage_sel_bits);
    return (sel_bits + stage_sel_bits - 1) / stage_sel_bits;
  endfunction

  // Entries entering stage k: ceil(in_num / 2^(k*stage_sel_bits)).
  function automatic int stage_entries(input int in_num, input int stage_sel_bits, input int k);
    int shift;
    shift = k * stage_sel_bits;
    if (shift >= 30) return 1;
    return (in_num + (1 << shift) - 1) >> shift;
  endfunction

  // Entry offset of stage k's input within the flattened data chain.
  function automatic int entry_offset(input int in_num, input int stage_sel_bits, input int k);
    int sum;
    sum = 0;
    for (int i = 0; i < k; i++) sum += stage_entries(in_num, stage_sel_bits, i);
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_pipeline_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_pipeline_stage : one register level reducing groups of 2^GROUP_BITS entries
// Rev 1.0
// ---------------------------------------------------------------------------
module mux_pipeline_stage #(
  parameter int SEL_BITS    = 4,
  parameter int DATA_BITS   = 1,
  parameter int IN_ENTRIES  = 16,
  parameter int OUT_ENTRIES = 4,
  parameter int SEL_LSB     = 0,
  parameter int GROUP_BITS  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             advance,
  input  logic                             in_valid,
  input  logic [SEL_BITS-1:0]              in_sel,
  input  logic [IN_ENTRIES*DATA_BITS-1:0]  in_data,
  output logic                             out_valid,
  output logic [SEL_BITS-1:0]              out_sel,
  output logic [OUT_ENTRIES*DATA_BITS-1:0] out_data
);

  localparam int GROUP_SIZE = 1 << GROUP_BITS;
  localparam int PADDED     = OUT_ENTRIES * GROUP_SIZE;

  logic [GROUP_BITS-1:0]            field;
  logic [PADDED*DATA_BITS-1:0]      padded;
  logic [OUT_ENTRIES*DATA_BITS-1:0] mux_data;

  assign field = in_sel[SEL_LSB +: GROUP_BITS];

  // Partial trailing group reads zeros, which also yields 0 for sel >= IN_NUM.
  always_comb begin
    padded = '0;
    padded[IN_ENTRIES*DATA_BITS-1:0] = in_data;
  end

  always_comb begin
    mux_data = '0;
    for (int j = 0; j < OUT_ENTRIES; j++) begin
      mux_data[j*DATA_BITS +: DATA_BITS] =
        padded[(j*GROUP_SIZE + int'(field))*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_sel   <= in_sel;
      out_data  <= mux_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_pipeline.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_pipeline : pipelined wide multiplexer with valid/ready handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module mux_pipeline
  import mux_pipeline_pkg::*;
#(
  parameter int SEL_BITS       = 4,
  parameter int DATA_BITS      = 1,
  parameter int IN_NUM         = 1 << SEL_BITS,
  parameter int STAGE_SEL_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cke,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [SEL_BITS-1:0]         sel,
  input  logic [IN_NUM*DATA_BITS-1:0] din,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_BITS-1:0]        dout
);

  localparam int STAGES   = calc_stages(SEL_BITS, STAGE_SEL_BITS);
  localparam int LAST_OFF = entry_offset(IN_NUM, STAGE_SEL_BITS, STAGES);
  localparam int TOTAL    = LAST_OFF + 1;

  logic                       advance;
  logic [TOTAL*DATA_BITS-1:0] data_chain;
  logic [STAGES:0]            valid_chain;
  logic [SEL_BITS-1:0]        sel_chain [0:STAGES];
  logic                       unused_last_sel;

  // Bubbles advance too, so the pipe only stalls on real backpressure.
  assign advance = cke && (m_ready || !m_valid);
  assign s_ready = advance;

  assign valid_chain[0]                   = s_valid;
  assign sel_chain[0]                     = sel;
  assign data_chain[IN_NUM*DATA_BITS-1:0] = din;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_OFF     = entry_offset(IN_NUM, STAGE_SEL_BITS, k);
    localparam int OUT_OFF    = entry_offset(IN_NUM, STAGE_SEL_BITS, k + 1);
    localparam int IN_ENT     = stage_entries(IN_NUM, STAGE_SEL_BITS, k);
    localparam int OUT_ENT    = stage_entries(IN_NUM, STAGE_SEL_BITS, k + 1);
    localparam int SEL_LSB    = k * STAGE_SEL_BITS;
    localparam int GROUP_BITS = (SEL_BITS - SEL_LSB < STAGE_SEL_BITS) ?
                                (SEL_BITS - SEL_LSB) : STAGE_SEL_BITS;

    mux_pipeline_stage #(
      .SEL_BITS    (SEL_BITS),
      .DATA_BITS   (DATA_BITS),
      .IN_ENTRIES  (IN_ENT),
      .OUT_ENTRIES (OUT_ENT),
      .SEL_LSB     (SEL_LSB),
      .GROUP_BITS  (GROUP_BITS)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .advance   (advance),
      .in_valid  (valid_chain[k]),
      .in_sel    (sel_chain[k]),
      .in_data   (data_chain[IN_OFF*DATA_BITS +: IN_ENT*DATA_BITS]),
      .out_valid (valid_chain[k+1]),
      .out_sel   (sel_chain[k+1]),
      .out_data  (data_chain[OUT_OFF*DATA_BITS +: OUT_ENT*DATA_BITS])
    );
  end

  assign m_valid         = valid_chain[STAGES];
  assign dout            = data_chain[LAST_OFF*DATA_BITS +: DATA_BITS];
  assign unused_last_sel = ^sel_chain[STAGES];

endmodule
`default_nettype wire

// File: doc/mux_pipeline.md
MUX_PIPELINE -- requirements
Module: mux_pipeline

Interface
REQ-001 Parameter SEL_BITS, default 4, width of the select input.
REQ-002 Parameter DATA_BITS, default 1, width of each data input and of the output.
REQ-003 Parameter IN_NUM, default 1<<SEL_BITS, number of data inputs, legal range 2..(1<<SEL_BITS).
REQ-004 Parameter STAGE_SEL_BITS, default 2, select bits consumed per pipeline stage, legal range 1..SEL_BITS.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port reset, input, 1, synchronous, active-high reset.
REQ-007 Port cke, input, 1, global clock enable; 0 freezes all state.
REQ-008 Port s_valid, input, 1, marks sel/din as a valid request.
REQ-009 Port s_ready, output, 1, request accepted when s_valid && s_ready at a clock edge.
REQ-010 Port sel, input, SEL_BITS, index of the selected input.
REQ-011 Port din, input, IN_NUM*DATA_BITS, input i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-012 Port m_valid, output, 1, dout holds a valid result.
REQ-013 Port m_ready, input, 1, downstream accepts the result when m_valid && m_ready.
REQ-014 Port dout, output, DATA_BITS, selected data.

Function
REQ-015 STAGES SHALL equal ceil(SEL_BITS/STAGE_SEL_BITS), and each stage SHALL be one register level.
REQ-016 Stage k SHALL reduce groups of 2^STAGE_SEL_BITS adjacent entries using sel bits [k*STAGE_SEL_BITS +: STAGE_SEL_BITS], LSB group first.
REQ-017 The last stage SHALL use only the remaining sel bits when SEL_BITS is not a multiple of STAGE_SEL_BITS.
REQ-018 Unused sel bits SHALL be carried forward in the stage registers alongside the partial results.
REQ-019 The pipeline SHALL advance only when advance = cke && (m_ready || !m_valid).
REQ-020 s_ready SHALL equal advance, as a combinational function of cke, m_ready and m_valid.
REQ-021 On advance, the stage 0 valid SHALL load s_valid, and the valid of stage k SHALL load the valid of stage k-1.
REQ-022 m_valid SHALL be the valid of the last stage.
REQ-023 Latency from acceptance to m_valid SHALL be exactly STAGES cycles with no stalls.
REQ-024 Throughput SHALL be one result per cycle while advance is held high.
REQ-025 While advance is low, all data, sel and valid registers SHALL hold, and dout SHALL stay stable with m_valid high.
REQ-026 Stages holding invalid data (bubbles) SHALL still advance, so they do not block upstream.
REQ-027 If sel >= IN_NUM, dout SHALL be 0 for that request, and the request still produces m_valid.
REQ-028 Data registers SHALL load on advance regardless of valid; dout is don't-care when m_valid is 0.
REQ-029 When STAGES == 1, the block SHALL behave as a single registered mux with the handshake above.

Reset
REQ-030 While reset is high, all valid registers and m_valid SHALL be 0 at the next clock edge, independent of cke.
REQ-031 While reset is high, dout SHALL be 0.
REQ-032 Reset mid-operation SHALL discard all in-flight requests, and no m_valid SHALL appear for them afterwards.
REQ-033 During reset, s_ready SHALL follow REQ-020, and requests accepted in the reset cycle SHALL be dropped.

Structure
REQ-034 The package mux_pipeline_pkg SHALL hold a function computing STAGES and the per-stage entry count ceil(IN_NUM/2^(k*STAGE_SEL_BITS)).
REQ-035 One sub-module, mux_pipeline_stage, SHALL implement a single register level: group mux, valid and sel carry, and advance/reset.
REQ-036 The top level SHALL instantiate mux_pipeline_stage STAGES times in a generate loop.
REQ-037 Out-of-range inputs of partial groups SHALL be padded with zero.

Verification
REQ-038 Test with SEL_BITS=4, DATA_BITS=8, STAGE_SEL_BITS=2, din[i]=i+0x10, cke=1, m_ready=1: sweep sel 0..15, one request per cycle -> dout=sel+0x10, m_valid exactly 2 cycles after each accept, back-to-back.
REQ-039 Test backpressure: m_ready=0 for 5 cycles with 3 requests in flight -> s_ready=0, dout and m_valid frozen, results in order with none lost or duplicated after m_ready=1.
REQ-040 Test with IN_NUM=10, sel=12 -> dout=0x00 with m_valid=1; sel=9 -> dout=0x19.
REQ-041 Test with SEL_BITS=5, STAGE_SEL_BITS=2 (3 stages, last uses 1 bit), sel=0x1F, IN_NUM=32 -> dout=din[31] after 3 cycles.
REQ-042 Test reset asserted with 2 requests in flight -> m_valid=0 and dout=0 on the next edge, and no stale result after reset is released.
REQ-043 Test cke=0 for 4 cycles mid-stream -> no state change and s_ready=0, and the stream resumes unchanged when cke=1.
